alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the 32-bit combinational ALU for the MIPS datapath.
//  Registers the operands on accept and returns the result plus ADD/SUB/XOR/SLT/AND/NAND/NOR/OR
//  flags one cycle later. Adds multi-cycle SLL/SRL/SRA (1 bit/cycle) and MULTU (shift-add, HI/LO).
//  Sits between decode and writeback; stalls upstream via in_ready.
// PARAMETERS
//  WIDTH   32  operand/result width, >=4, power of two
//  SHW     $clog2(WIDTH)  shift-amount width (derived localparam, not overridable)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/command presented
//  in_ready   out  1      block can accept; transfer when in_valid&&in_ready
//  command    in   4      0 ADD,1 SUB,2 XOR,3 SLT,4 AND,5 NAND,6 NOR,7 OR,8 SLL,9 SRL,10 SRA,11 MULTU
//  operandA   in   WIDTH  first operand (shift: value to shift)
//  operandB   in   WIDTH  second operand (shift: amount in B[SHW-1:0], upper bits ignored)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result when out_valid&&out_ready
//  result     out  WIDTH  result (MULTU: low half)
//  result_hi  out  WIDTH  MULTU high half; 0 for every other command
//  carryout   out  1      ADD/SUB carry (SUB = A+~B+1); 0 otherwise
//  overflow   out  1      ADD/SUB signed overflow; 0 otherwise
//  zero       out  1      (result==0) && !overflow; MULTU: {result_hi,result}==0
//  cmd_err    out  1      command 12..15 issued; result/result_hi/flags forced 0
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, all data/flag outputs 0, counters 0; any op aborted.
//  FSM: IDLE -accept- single-cycle op, shamt==0 shift or cmd_err -> DONE next edge;
//       IDLE -accept- shift(shamt>0) or MULTU -> BUSY; BUSY -count expires-> DONE;
//       DONE -out_ready- IDLE, or straight back to BUSY/DONE if a new op accepted same edge.
//  in_ready = (state==IDLE) || (state==DONE && out_ready); 0 throughout BUSY.
//  in_valid while in_ready=0 is ignored; inputs need not be held after acceptance.
//  Latency accept->out_valid: ops 0-7, errors: 1 cycle; shifts: 1+shamt; MULTU: WIDTH+1.
//  Back-to-back single-cycle ops with out_ready=1: one result per cycle, no bubble.
//  DONE with out_ready=0: all outputs held bit-stable until consumed; out_valid stays 1.
//  SLT: result = {WIDTH-1 zeros, signed(A)<signed(B)} from sign^overflow of A-B; carry/ovf=0.
//  NAND/NOR are bitwise inversions of AND/OR; XOR bitwise.
//  SRA replicates operandA[WIDTH-1]; SLL/SRL fill 0; shamt=WIDTH-1 max, never wraps.
//  MULTU unsigned: {result_hi,result}=A*B exact 2*WIDTH; A or B 0 still takes WIDTH+1.
//  Flags and zero latched together with result in DONE; never change during BUSY.
//  Reset asserted in BUSY/DONE: returns to IDLE immediately; pending result discarded.
// STRUCTURE
//  alu_pkg: command encodings (ALU_ADD..ALU_MULTU), state enum {IDLE,BUSY,DONE},
//           helper localparams for flag-zero defaults.
//  Sub-module alu_comb: combinational WIDTH-bit datapath for commands 0-7
//    (result, carryout, overflow); alu_seq owns FSM, operand regs, shift/multiply iterators.
//  Shift counter SHW bits; multiply counter SHW+1 bits; accumulator 2*WIDTH bits.
// TESTING (WIDTH=32)
//  ADD 0x7FFFFFFF+1, out_ready=1 -> next cycle result 0x80000000, ovf=1, carry=0, zero=0.
//  SUB 5-5 -> result 0, carry=1, ovf=0, zero=1; SLT -1,1 -> result 1.
//  SRA 0x80000000 by 4 -> out_valid 5 cycles after accept, result 0xF8000000, in_ready=0 in between.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, zero=0.
//  DONE, out_ready=0 for 10 cycles -> outputs unchanged; then 3 back-to-back ORs -> 3 results in 3 cycles.
//  reset pulse mid-MULTU -> out_valid=0, outputs 0, in_ready=1; command 13 -> cmd_err=1, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the handshaked sequential ALU.
// Command codes, controller states and flag defaults.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_AND   = 4'd4,
    ALU_NAND  = 4'd5,
    ALU_NOR   = 4'd6,
    ALU_OR    = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_MULTU = 4'd11
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam logic FLAG_CLR = 1'b0;
  localparam logic [3:0] CMD_LAST_ALU = 4'd7;
  localparam logic [3:0] CMD_LAST = 4'd11;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath for ADD..OR.
// SUB and SLT share the A+~B+1 adder.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0] add_w;
  logic [WIDTH:0] sub_w;
  logic           add_ovf;
  logic           sub_ovf;

  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} + {1'b0, ~b_i}
               + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (a_i[M] == b_i[M])
                && (add_w[M] != a_i[M]);
  assign sub_ovf = (a_i[M] != b_i[M])
                && (sub_w[M] != a_i[M]);

  always_comb begin
    res_o   = '0;
    carry_o = FLAG_CLR;
    ovf_o   = FLAG_CLR;
    case (op_i)
      ALU_ADD: begin
        res_o   = add_w[M:0];
        carry_o = add_w[WIDTH];
        ovf_o   = add_ovf;
      end
      ALU_SUB: begin
        res_o   = sub_w[M:0];
        carry_o = sub_w[WIDTH];
        ovf_o   = sub_ovf;
      end
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_SLT:  res_o = {{M{1'b0}}, sub_w[M] ^ sub_ovf};
      ALU_AND:  res_o = a_i & b_i;
      ALU_NAND: res_o = ~(a_i & b_i);
      ALU_NOR:  res_o = ~(a_i | b_i);
      ALU_OR:   res_o = a_i | b_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one-cycle logic ops, bit-serial shifts,
// shift-add MULTU; results held in DONE until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             cmd_err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W2  = 2 * WIDTH;

  alu_state_e         state_q;
  logic [3:0]         op_q;
  logic [W2-1:0]      acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [SHW-1:0]     shcnt_q;
  logic [SHW:0]       mcnt_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   hi_q;
  logic               carry_q;
  logic               ovf_q;
  logic               zero_q;
  logic               err_q;

  logic               accept;
  logic [WIDTH-1:0]   comb_res;
  logic               comb_c;
  logic               comb_o;
  logic [SHW-1:0]     shamt;
  logic               is_err;
  logic               is_alu;
  logic               is_sft0;
  logic               is_sftn;
  logic               is_mul;
  logic [WIDTH:0]     sum_w;
  logic [W2-1:0]      mul_d;
  logic [WIDTH-1:0]   sh_d;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i     (operandA),
    .b_i     (operandB),
    .op_i    (command),
    .res_o   (comb_res),
    .carry_o (comb_c),
    .ovf_o   (comb_o)
  );

  assign in_ready  = (state_q == IDLE)
                  || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  assign shamt   = operandB[SHW-1:0];
  assign is_err  = command > CMD_LAST;
  assign is_alu  = command <= CMD_LAST_ALU;
  assign is_mul  = command == ALU_MULTU;
  assign is_sft0 = !is_err && !is_alu && !is_mul
                && (shamt == '0);
  assign is_sftn = !is_err && !is_alu && !is_mul
                && (shamt != '0);

  // acc_q holds {partial hi, remaining multiplier}
  always_comb begin
    sum_w = {1'b0, acc_q[W2-1:WIDTH]}
          + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_d = {sum_w, acc_q[WIDTH-1:1]};
    case (op_q)
      ALU_SLL: sh_d = {acc_q[WIDTH-2:0], 1'b0};
      ALU_SRL: sh_d = {1'b0, acc_q[WIDTH-1:1]};
      default: sh_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      shcnt_q <= '0;
      mcnt_q  <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= FLAG_CLR;
      ovf_q   <= FLAG_CLR;
      zero_q  <= FLAG_CLR;
      err_q   <= FLAG_CLR;
    end else begin
      case (state_q)
        BUSY: begin
          if (op_q == ALU_MULTU) begin
            acc_q  <= mul_d;
            mcnt_q <= mcnt_q - 1'b1;
            if (mcnt_q == (SHW+1)'(1)) begin
              res_q   <= mul_d[WIDTH-1:0];
              hi_q    <= mul_d[W2-1:WIDTH];
              zero_q  <= (mul_d == '0);
              carry_q <= FLAG_CLR;
              ovf_q   <= FLAG_CLR;
              err_q   <= FLAG_CLR;
              state_q <= DONE;
            end
          end else begin
            acc_q[WIDTH-1:0] <= sh_d;
            shcnt_q <= shcnt_q - 1'b1;
            if (shcnt_q == SHW'(1)) begin
              res_q   <= sh_d;
              hi_q    <= '0;
              zero_q  <= (sh_d == '0);
              carry_q <= FLAG_CLR;
              ovf_q   <= FLAG_CLR;
              err_q   <= FLAG_CLR;
              state_q <= DONE;
            end
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: ;
      endcase
      if (accept) begin
        op_q <= command;
        unique case (1'b1)
          is_err: begin
            res_q   <= '0;
            hi_q    <= '0;
            carry_q <= FLAG_CLR;
            ovf_q   <= FLAG_CLR;
            zero_q  <= FLAG_CLR;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
          is_alu: begin
            res_q   <= comb_res;
            hi_q    <= '0;
            carry_q <= comb_c;
            ovf_q   <= comb_o;
            zero_q  <= (comb_res == '0) && !comb_o;
            err_q   <= FLAG_CLR;
            state_q <= DONE;
          end
          is_sft0: begin
            res_q   <= operandA;
            hi_q    <= '0;
            carry_q <= FLAG_CLR;
            ovf_q   <= FLAG_CLR;
            zero_q  <= (operandA == '0);
            err_q   <= FLAG_CLR;
            state_q <= DONE;
          end
          is_sftn: begin
            acc_q   <= {{WIDTH{1'b0}}, operandA};
            shcnt_q <= shamt;
            state_q <= BUSY;
          end
          is_mul: begin
            acc_q   <= {{WIDTH{1'b0}}, operandB};
            mcand_q <= operandA;
            mcnt_q  <= (SHW+1)'(WIDTH);
            state_q <= BUSY;
          end
        endcase
      end
    end
  end

  assign result    = res_q;
  assign result_hi = hi_q;
  assign carryout  = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq against a plain-arithmetic
// reference model of results, flags and latency.
module tb_alu_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] hi;
    logic        c;
    logic        o;
    logic        z;
    logic        e;
    logic [7:0]  lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    command = '0;
  logic [W-1:0]  operandA = '0;
  logic [W-1:0]  operandB = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          carryout;
  logic          overflow;
  logic          zero;
  logic          cmd_err;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .command   (command),
    .operandA  (operandA),
    .operandB  (operandB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carryout  (carryout),
    .overflow  (overflow),
    .zero      (zero),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t x;
    longint sa, sb, s;
    logic [32:0] u;
    logic [63:0] p;
    logic signed [31:0] as_;
    int sh;
    x = '0;
    x.lat = 8'd1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    as_ = a;
    sh = int'(b[4:0]);
    s = 0;
    p = '0;
    case (c)
      4'd0: begin
        u = {1'b0, a} + {1'b0, b};
        x.r = u[31:0]; x.c = u[32];
        s = sa + sb;
        x.o = (s != longint'($signed(x.r)));
      end
      4'd1: begin
        u = {1'b0, a} + {1'b0, ~b} + 33'd1;
        x.r = u[31:0]; x.c = u[32];
        s = sa - sb;
        x.o = (s != longint'($signed(x.r)));
      end
      4'd2: x.r = a ^ b;
      4'd3: x.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: x.r = a & b;
      4'd5: x.r = ~(a & b);
      4'd6: x.r = ~(a | b);
      4'd7: x.r = a | b;
      4'd8:  begin x.r = a << sh; x.lat = 8'(1 + sh); end
      4'd9:  begin x.r = a >> sh; x.lat = 8'(1 + sh); end
      4'd10: begin x.r = as_ >>> sh; x.lat = 8'(1 + sh); end
      4'd11: begin
        p = 64'(a) * 64'(b);
        x.r = p[31:0]; x.hi = p[63:32];
        x.lat = 8'(W + 1);
      end
      default: x.e = 1'b1;
    endcase
    if (c == 4'd11) x.z = (p == 64'd0);
    else if (!x.e) x.z = (x.r == 32'd0) && !x.o;
    return x;
  endfunction

  task automatic chk_outs(input exp_t x);
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("result", 64'(result), 64'(x.r));
    chk("result_hi", 64'(result_hi), 64'(x.hi));
    chk("carryout", 64'(carryout), 64'(x.c));
    chk("overflow", 64'(overflow), 64'(x.o));
    chk("cmd_err", 64'(cmd_err), 64'(x.e));
    if (!x.e) chk("zero", 64'(zero), 64'(x.z));
  endtask

  task automatic run_op(input logic [3:0] c,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int hold);
    exp_t x;
    int lat;
    x = model(c, a, b);
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    command = c;
    operandA = a;
    operandB = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    command = 4'($urandom);
    operandA = $urandom;
    operandB = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(x.lat));
    chk_outs(x);
    repeat (hold) begin
      @(posedge clk); #1;
      chk_outs(x);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("consumed", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] oa [3];
    logic [31:0] ob [3];
    logic [3:0]  rc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({result_hi, carryout,
        overflow, zero, cmd_err}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(4'd0, 32'h7FFFFFFF, 32'h1, 0);
    run_op(4'd1, 32'd5, 32'd5, 0);
    run_op(4'd3, 32'hFFFFFFFF, 32'd1, 0);
    run_op(4'd10, 32'h80000000, 32'd4, 0);
    run_op(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(4'd11, 32'd0, 32'h1234, 0);
    run_op(4'd9, 32'hDEADBEEF, 32'hFFFFFFE0, 0);
    run_op(4'd8, 32'h00000003, 32'd31, 0);
    run_op(4'd10, 32'h80000001, 32'd31, 0);
    run_op(4'd13, 32'h1234, 32'h5678, 0);
    run_op(4'd0, 32'hA5A5A5A5, 32'h01010101, 10);

    // three ORs streamed with out_ready held high
    oa[0] = 32'h0000F000; ob[0] = 32'h0000000F;
    oa[1] = 32'h12000000; ob[1] = 32'h00340000;
    oa[2] = 32'h0;        ob[2] = 32'h0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      command = 4'd7;
      operandA = oa[i];
      operandB = ob[i];
      @(posedge clk); #1;
      chk("b2b_valid", 64'(out_valid), 64'd1);
      chk("b2b_result", 64'(result), 64'(oa[i] | ob[i]));
      chk("b2b_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    run_op(4'd7, 32'hCAFE0000, 32'h0000BABE, 0);
    @(negedge clk);
    in_valid = 1'b1;
    command = 4'd11;
    operandA = 32'hFFFF0000;
    operandB = 32'h0000FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_data", 64'({result_hi, result}), 64'd0);
    chk("mid_rst_flags", 64'({carryout, overflow,
        zero, cmd_err}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op(rc, ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
